// File: rtl/game_pkg.sv
// Shared game definitions: the game-mode encoding used by the mode controller
// and the board-to-board frame constants shared by transmitter and receiver.
package game_pkg;

  typedef enum logic [1:0] {
    START       = 2'd0,
    GAME        = 2'd1,
    PLAYER1_WIN = 2'd2,
    PLAYER2_WIN = 2'd3
  } game_mode;

  localparam logic [7:0] FRAME_HEADER = 8'hA5;
  localparam int         FRAME_BYTES  = 3;

  // Frame-level states of the game-state transmitter.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } tx_state_e;

  // Payload byte: collision flag above the two mode bits.
  function automatic logic [7:0] frame_byte1(input logic coll, input game_mode m);
    return {5'b0, coll, m};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, eight data bits LSB first, stop bit.
// ready is also high during the last cycle of the stop bit so the next byte
// can be loaded on that edge, giving back-to-back bytes with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    shift_q, shift_d;
  logic          active_q, active_d;
  logic          bit_end;

  assign bit_end = active_q && (baud_q == CW'(CLKS_PER_BIT - 1));
  assign ready   = !active_q || (bit_end && (bit_q == 4'd9));
  // The line is the low bit of the shifter; ones shift in so idle reads high.
  assign tx      = shift_q[0];

  // Baud timing and shifting; a fresh load overrides the end-of-byte update.
  always_comb begin
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    active_d = active_q;
    if (active_q) begin
      if (bit_end) begin
        baud_d  = '0;
        shift_d = {1'b1, shift_q[9:1]};
        if (bit_q == 4'd9) begin
          active_d = 1'b0;
          bit_d    = 4'd0;
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end else begin
        baud_d = baud_q + CW'(1);
      end
    end
    if (start && ready) begin
      shift_d  = {1'b1, data, 1'b0};
      baud_d   = '0;
      bit_d    = 4'd0;
      active_d = 1'b1;
    end
  end

  // Serializer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_q   <= '0;
      bit_q    <= 4'd0;
      shift_q  <= '1;
      active_q <= 1'b0;
    end else begin
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/game_state_tx.sv
// Game-state transmitter: sends {A5, coll/mode, checksum} frames to the
// opponent's board whenever the state needs to be (re)announced.
// Optional feature macro GAME_STATE_TX_HEARTBEAT_EN: periodic resend of the
// unchanged state every HEARTBEAT_CLKS idle clocks. CLK_HZ/BAUD must be >= 4.
module game_state_tx
  import game_pkg::*;
#(
  parameter int CLK_HZ         = 65_000_000,
  parameter int BAUD           = 115_200,
  parameter int HEARTBEAT_CLKS = 6_500_000
) (
  input  logic     clk,
  input  logic     rst,
  input  game_mode mode,
  input  logic     player1_collision,
  output logic     tx,
  output logic     busy,
  output logic     frame_done
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  tx_state_e  state_q, state_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [7:0] byte1_q, byte1_d;
  game_mode   last_mode_q, last_mode_d;
  logic       sent_valid_q, sent_valid_d;
  logic       coll_pend_q, coll_pend_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       uart_start, uart_ready;
  logic [7:0] uart_data;
  logic       hb_expired;
  logic       pending;

  assign pending = !sent_valid_q || (mode != last_mode_q) || coll_pend_q || hb_expired;

`ifdef GAME_STATE_TX_HEARTBEAT_EN
  localparam int HBW = $clog2(HEARTBEAT_CLKS + 1);
  logic [HBW-1:0] hb_q, hb_d;
  logic           hb_snapshot;

  assign hb_snapshot = (state_q == ST_IDLE) && pending;
  assign hb_expired  = (hb_q == HBW'(HEARTBEAT_CLKS - 1));

  // Heartbeat counts idle clocks and restarts from zero at every snapshot.
  always_comb begin
    hb_d = hb_q;
    if (state_q == ST_IDLE) begin
      hb_d = hb_snapshot ? '0 : hb_q + HBW'(1);
    end
  end

  // Heartbeat counter register.
  always_ff @(posedge clk) begin
    if (rst) hb_q <= '0;
    else     hb_q <= hb_d;
  end
`else
  // No heartbeat hardware; the period parameter stays only for a uniform
  // instantiation interface and folds to a constant false.
  assign hb_expired = 1'b0 & (HEARTBEAT_CLKS == 0);
`endif

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .rst  (rst),
    .start(uart_start),
    .data (uart_data),
    .tx   (tx),
    .ready(uart_ready)
  );

  // Frame sequencing, change detection and collision latch.
  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    byte1_d      = byte1_q;
    last_mode_d  = last_mode_q;
    sent_valid_d = sent_valid_q;
    coll_pend_d  = coll_pend_q | player1_collision;
    busy_d       = busy_q;
    done_d       = 1'b0;
    uart_start   = 1'b0;
    uart_data    = FRAME_HEADER;
    case (state_q)
      ST_IDLE: begin
        if (pending) begin
          // Snapshot: a collision arriving right now waits for the next frame.
          uart_start   = 1'b1;
          uart_data    = FRAME_HEADER;
          byte1_d      = frame_byte1(coll_pend_q, mode);
          last_mode_d  = mode;
          sent_valid_d = 1'b1;
          coll_pend_d  = player1_collision;
          busy_d       = 1'b1;
          byte_idx_d   = 2'd0;
          state_d      = ST_SEND;
        end
      end
      ST_SEND: begin
        if (uart_ready) begin
          if (byte_idx_q == 2'(FRAME_BYTES - 1)) begin
            state_d    = ST_DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            byte_idx_d = 2'd0;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            uart_start = 1'b1;
            uart_data  = (byte_idx_q == 2'd0) ? byte1_q : (FRAME_HEADER ^ byte1_q);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame state register; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      byte_idx_q   <= 2'd0;
      byte1_q      <= 8'd0;
      last_mode_q  <= START;
      sent_valid_q <= 1'b0;
      coll_pend_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      byte1_q      <= byte1_d;
      last_mode_q  <= last_mode_d;
      sent_valid_q <= sent_valid_d;
      coll_pend_q  <= coll_pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_game_state_tx.sv
// Bench for game_state_tx: decodes the serial line, predicts frame content
// and snapshot timing from an input log, plus table and hand sequences.
module tb_game_state_tx;
  import game_pkg::*;

  localparam int CPB        = 10;
  localparam int FRAME_CLKS = 30 * CPB;
  localparam int HB         = 500;
  localparam int LOGN       = 1 << 17;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     player1_collision = 1'b0;
  game_mode mode = START;
  logic     tx, busy, frame_done;

  game_state_tx #(
    .CLK_HZ(1000), .BAUD(100), .HEARTBEAT_CLKS(HB)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .player1_collision(player1_collision),
    .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Input log indexed by posedge number.
  int         ecnt = 0;
  logic [1:0] mode_log [LOGN];
  bit         coll_log [LOGN];
  int         rst_gen = 0;
  int         R = 0;
  bit         first_pending = 1'b1;

  // Monitor results.
  int         P = 0;
  logic [1:0] last_sent = 2'd0;
  int         frames_seen = 0;
  int         frame_starts = 0;
  logic [7:0] last_b1 = 8'd0, last_b2 = 8'd0;
  int         last_snap = 0;
  int         idle_glitch = 0;

  typedef struct {
    game_mode   m;
    bit         coll;
    logic [7:0] b1;
    logic [7:0] b2;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h (edge %0d)", name, act, exp, ecnt);
  endtask

  function automatic bit coll_between(input int a, input int b);
    bit c = 1'b0;
    for (int e = a; e < b; e++) c |= coll_log[e];
    return c;
  endfunction

  // First edge at or after the earliest legal snapshot where a frame is owed.
  function automatic int predict(input int upto);
    int earliest = first_pending ? R : P + FRAME_CLKS + 2;
    int cstart   = first_pending ? R : P;
    bit c        = coll_between(cstart, earliest);
    for (int e = earliest; e <= upto; e++) begin
      if (first_pending || (mode_log[e] != last_sent) || c) return e;
`ifdef GAME_STATE_TX_HEARTBEAT_EN
      if (e == P + FRAME_CLKS + 1 + HB) return e;
`endif
      c |= coll_log[e];
    end
    return -1;
  endfunction

  // Log what the DUT samples on every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      ecnt++;
      mode_log[ecnt] = mode;
      coll_log[ecnt] = player1_collision;
      if (rst) begin
        rst_gen++;
        R = ecnt + 1;
        first_pending = 1'b1;
      end
    end
  end

  // Line monitor: decodes each frame and checks it against the log.
  initial begin : mon
    int S, g, pred, cstart, off;
    bit ab;
    logic [7:0] exp_b1;
    logic [29:0] fb;
    forever begin
      @(negedge clk);
      if (busy !== 1'b1) begin
        if (tx !== 1'b1 || frame_done !== 1'b0) idle_glitch++;
        continue;
      end
      S = ecnt;
      g = rst_gen;
      pred = predict(S);
      check("snapshot_edge", S, pred);
      cstart = first_pending ? R : P;
      exp_b1 = {5'b0, coll_between(cstart, S), mode_log[S]};
      P = S;
      last_sent = mode_log[S];
      first_pending = 1'b0;
      frame_starts++;
      check("start_bit", {busy, tx}, 2'b10);
      off = 0;
      ab = 1'b0;
      fb = '0;
      for (int k = 0; k < 30; k++) begin
        while (!ab && off < k * CPB + CPB / 2) begin
          @(negedge clk); off++;
          if (rst_gen != g) ab = 1'b1;
        end
        if (ab) break;
        fb[k] = tx;
      end
      while (!ab && off < FRAME_CLKS - 1) begin
        @(negedge clk); off++;
        if (rst_gen != g) ab = 1'b1;
      end
      if (ab) continue;
      check("busy_before_done", {busy, frame_done}, 2'b10);
      @(negedge clk);
      if (rst_gen != g) continue;
      check("frame_done_lat", {frame_done, busy, tx}, 3'b101);
      check("framing", {fb[0], fb[9], fb[10], fb[19], fb[20], fb[29]}, 6'b010101);
      check("byte0", fb[8:1], FRAME_HEADER);
      check("byte1_model", fb[18:11], exp_b1);
      check("byte2_model", fb[28:21], FRAME_HEADER ^ exp_b1);
      last_b1 = fb[18:11];
      last_b2 = fb[28:21];
      last_snap = S;
      frames_seen++;
    end
  end

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_seen < target && n < budget) begin @(negedge clk); n++; end
    if (frames_seen < target) check("frame_timeout", frames_seen, target);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n = 0;
    while (frame_starts < target && n < budget) begin @(negedge clk); n++; end
    if (frame_starts < target) check("start_timeout", frame_starts, target);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(busy === 1'b0 && frame_done === 1'b0) && n < budget) begin @(negedge clk); n++; end
    if (n >= budget) check("idle_timeout", {busy, frame_done}, 2'b00);
  endtask

  task automatic pulse_coll(input int len);
    player1_collision = 1'b1;
    repeat (len) @(negedge clk);
    player1_collision = 1'b0;
  endtask

  initial begin
    int base, snap1;
    tbl[0] = '{GAME,        1'b0, 8'h01, 8'hA4};
    tbl[1] = '{GAME,        1'b1, 8'h05, 8'hA0};
    tbl[2] = '{PLAYER2_WIN, 1'b0, 8'h03, 8'hA6};
    tbl[3] = '{PLAYER1_WIN, 1'b1, 8'h06, 8'hA3};
    tbl[4] = '{START,       1'b0, 8'h00, 8'hA5};
    tbl[5] = '{GAME,        1'b1, 8'h05, 8'hA0};

    repeat (4) @(negedge clk);
    check("reset_outputs", {tx, busy, frame_done}, 3'b100);
    rst = 1'b0;
    wait_frames(1, 400);
    check("reset_frame_b1", last_b1, 8'h00);
    check("reset_frame_b2", last_b2, 8'hA5);

    for (int i = 0; i < 6; i++) begin
      wait_idle(400);
      base = frames_seen;
      if (tbl[i].coll) pulse_coll(1);
      mode = tbl[i].m;
      wait_frames(base + 1, 400);
      check($sformatf("tbl%0d_b1", i), last_b1, tbl[i].b1);
      check($sformatf("tbl%0d_b2", i), last_b2, tbl[i].b2);
    end

    // Mode change in the middle of a frame is deferred to the next frame.
    wait_idle(400);
    base = frames_seen;
    pulse_coll(1);
    wait_starts(frame_starts + 1, 50);
    repeat (12 * CPB) @(negedge clk);
    mode = PLAYER2_WIN;
    wait_frames(base + 1, 400);
    check("inflight_b1", last_b1, 8'h05);
    snap1 = last_snap;
    wait_frames(base + 2, 400);
    check("deferred_b1", last_b1, 8'h03);
    check("deferred_b2", last_b2, 8'hA6);
    check("deferred_spacing", last_snap - snap1, FRAME_CLKS + 2);

    // Reset in the middle of a frame.
    wait_idle(400);
    mode = GAME;
    wait_starts(frame_starts + 1, 50);
    repeat (15 * CPB) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_midframe", {tx, busy, frame_done}, 3'b100);
    rst = 1'b0;
    base = frames_seen;
    wait_frames(base + 1, 400);
    check("post_rst_b1", last_b1, 8'h01);
    check("post_rst_b2", last_b2, 8'hA4);

    // Constant state: repeats only with the heartbeat.
    wait_idle(400);
    base = frames_seen;
    repeat (5000) @(negedge clk);
`ifdef GAME_STATE_TX_HEARTBEAT_EN
    check("heartbeat_repeats", (frames_seen - base) >= 5, 1);
    check("heartbeat_b1", last_b1, 8'h01);
`else
    check("no_repeat", frames_seen, base);
`endif

    // Random mode changes and collision pulses, including mid-frame.
    for (int i = 0; i < 60; i++) begin
      int r;
      repeat ($urandom_range(0, 350)) @(negedge clk);
      r = $urandom_range(0, 3);
      if (r == 0 || r == 2) mode = game_mode'(2'($urandom_range(0, 3)));
      if (r == 1 || r == 2) pulse_coll($urandom_range(1, 3));
    end
    repeat (400) @(negedge clk);
    wait_idle(800);
    check("no_missed_frame", predict(ecnt), 32'hFFFF_FFFF);
    check("idle_glitches", idle_glitch, 0);
    check("frames_observed", frames_seen > 15, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
